// File: rtl/btb_pred_mw.sv
// btb_pred_mw: fully-associative branch target buffer with saturating
// direction counters.
//
// Fetch looks up a PC on the lookup port and receives a registered
// prediction one cycle later. The branch unit reports resolved branches on
// the update port. Those reports train the counters, correct targets, and
// allocate entries for taken branches that missed.
//
// Optional feature macro: BTB_PRED_BYPASS_EN
//   Undefined: a lookup always reads the state from before this cycle's
//              update or flush.
//   Defined:   a lookup whose PC matches a same-cycle valid update sees the
//              post-update entry. A lookup in a flush cycle misses.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   flush_i        invalidate every entry at the next edge
//   lkp_v_i        lookup request valid
//   lkp_pc_i       fetch PC to look up
//   pred_v_o       registered: previous-cycle lookup hit
//   pred_taken_o   registered: MSB of the hit entry's counter
//   pred_pc_o      registered: hit entry target (0 on miss)
//   upd_v_i        branch resolution valid
//   upd_pc_i       resolved branch PC
//   upd_target_i   resolved branch target
//   upd_taken_i    resolved branch direction

package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module btb_pred_mw import riscv_pkg::*; #(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            lkp_v_i,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            pred_v_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_pc_o,
  input  logic            upd_v_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [XLEN-1:0]    tag_q [ENTRIES];
  logic [XLEN-1:0]    tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_d [ENTRIES];
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               upd_hit;
  logic [PTR_W-1:0]   upd_idx;
  logic               free_found;
  logic [PTR_W-1:0]   free_idx;
  logic [PTR_W-1:0]   victim;

  logic               pred_v_q, pred_v_d;
  logic               pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]    pred_pc_q, pred_pc_d;

  // Locate the entry matching the update PC, and the lowest-index free slot.
  // Allocation only writes missing PCs, so at most one entry can match.
  // The free-slot scan runs from high to low so the lowest index wins.
  always_comb begin
    upd_hit    = 1'b0;
    upd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == upd_pc_i) begin
        upd_hit = 1'b1;
        upd_idx = PTR_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
    victim = free_found ? free_idx : ptr_q;
  end

  // Next table state.
  // A flush drops any concurrent update and keeps counters, targets and the
  // pointer as they are.
  // The pointer moves only when an allocation consumed the pointer entry.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (upd_v_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
          tgt_d[upd_idx] = upd_target_i;
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken_i) begin
        valid_d[victim] = 1'b1;
        tag_d[victim]   = upd_pc_i;
        tgt_d[victim]   = upd_target_i;
        cnt_d[victim]   = CNT_INIT;
        if (!free_found) ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Lookup.
  // With the bypass enabled, a lookup reads the next-state view when its PC
  // matches the update PC. It also reads that view during a flush, where the
  // cleared valid bits force a miss.
  always_comb begin
    logic            use_post;
    logic            ev;
    logic [XLEN-1:0] etag;
    logic [XLEN-1:0] etgt;
    logic [CNT_W-1:0] ecnt;
    pred_v_d     = 1'b0;
    pred_taken_d = 1'b0;
    pred_pc_d    = '0;
`ifdef BTB_PRED_BYPASS_EN
    use_post = flush_i | (upd_v_i & (lkp_pc_i == upd_pc_i));
`else
    use_post = 1'b0;
`endif
    for (int i = 0; i < ENTRIES; i++) begin
      ev   = use_post ? valid_d[i] : valid_q[i];
      etag = use_post ? tag_d[i]   : tag_q[i];
      etgt = use_post ? tgt_d[i]   : tgt_q[i];
      ecnt = use_post ? cnt_d[i]   : cnt_q[i];
      if (lkp_v_i && ev && etag == lkp_pc_i) begin
        pred_v_d     = 1'b1;
        pred_taken_d = pred_taken_d | ecnt[CNT_W-1];
        pred_pc_d    = pred_pc_d | etgt;
      end
    end
  end

  // State and prediction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      ptr_q        <= '0;
      pred_v_q     <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_INIT;
      end
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      pred_v_q     <= pred_v_d;
      pred_taken_q <= pred_taken_d;
      pred_pc_q    <= pred_pc_d;
    end
  end

  assign pred_v_o     = pred_v_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_pc_o    = pred_pc_q;

endmodule

// File: tb/tb_btb_pred_mw.sv
// Testbench for btb_pred_mw with the default parameters ENTRIES=8 and CNT_W=2.
// It drives a table of single-cycle vectors, then hand-written sequences
// covering asynchronous reset, replacement order and flush. Each expected
// prediction is pushed to a queue when its stimulus is driven. It is popped
// and compared once the registered outputs appear.

module tb_btb_pred_mw;

  logic        clk;
  logic        reset_n;
  logic        flush_i;
  logic        lkp_v_i;
  logic [31:0] lkp_pc_i;
  logic        pred_v_o;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;
  logic        upd_v_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;

  typedef struct {
    string       name;
    logic        flush;
    logic        lkpV;
    logic [31:0] lkpPc;
    logic        updV;
    logic [31:0] updPc;
    logic [31:0] updTgt;
    logic        updTaken;
    logic        expV;
    logic        expTaken;
    logic [31:0] expPc;
  } vec_t;

  typedef struct {
    string       name;
    logic        v;
    logic        taken;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [19];

  btb_pred_mw #(.ENTRIES(8), .CNT_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush_i),
    .lkp_v_i      (lkp_v_i),
    .lkp_pc_i     (lkp_pc_i),
    .pred_v_o     (pred_v_o),
    .pred_taken_o (pred_taken_o),
    .pred_pc_o    (pred_pc_o),
    .upd_v_i      (upd_v_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic fl, input logic lv,
                              input logic [31:0] lpc, input logic uv,
                              input logic [31:0] upc, input logic [31:0] utgt,
                              input logic ut, input logic ev, input logic et,
                              input logic [31:0] epc);
    vec_t r;
    r.name = n; r.flush = fl; r.lkpV = lv; r.lkpPc = lpc;
    r.updV = uv; r.updPc = upc; r.updTgt = utgt; r.updTaken = ut;
    r.expV = ev; r.expTaken = et; r.expPc = epc;
    return r;
  endfunction

  // Drive one cycle of inputs and queue the prediction they should produce.
  task automatic applyStimulus(input vec_t r);
    exp_t e;
    flush_i      = r.flush;
    lkp_v_i      = r.lkpV;
    lkp_pc_i     = r.lkpPc;
    upd_v_i      = r.updV;
    upd_pc_i     = r.updPc;
    upd_target_i = r.updTgt;
    upd_taken_i  = r.updTaken;
    e.name = r.name; e.v = r.expV; e.taken = r.expTaken; e.pc = r.expPc;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, required a pending expectation");
      return;
    end
    e = expQ.pop_front();
    checks++;
    if (pred_v_o !== e.v || pred_taken_o !== e.taken || pred_pc_o !== e.pc) begin
      errors++;
      $display("[TB] FAIL %s: got v=%0b taken=%0b pc=%h, required v=%0b taken=%0b pc=%h",
               e.name, pred_v_o, pred_taken_o, pred_pc_o, e.v, e.taken, e.pc);
    end
  endtask

  task automatic cycle(input vec_t r);
    applyStimulus(r);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Single-cycle vectors following entry 0x100 from reset through
    // saturation and target correction.
    vecs[0]  = mk("resetMiss",  0, 1, 32'h100, 0, 0, 0, 0,             0, 0, 32'h0);
    vecs[1]  = mk("alloc",      0, 0, 32'h0,   1, 32'h100, 32'h200, 1, 0, 0, 32'h0);
    vecs[2]  = mk("allocHit",   0, 1, 32'h100, 0, 0, 0, 0,             1, 1, 32'h200);
    vecs[3]  = mk("nt1",        0, 0, 32'h0,   1, 32'h100, 32'h200, 0, 0, 0, 32'h0);
    vecs[4]  = mk("nt2",        0, 0, 32'h0,   1, 32'h100, 32'h200, 0, 0, 0, 32'h0);
    vecs[5]  = mk("nt3",        0, 0, 32'h0,   1, 32'h100, 32'h200, 0, 0, 0, 32'h0);
    vecs[6]  = mk("satLow",     0, 1, 32'h100, 0, 0, 0, 0,             1, 0, 32'h200);
    vecs[7]  = mk("sameCycT1",  0, 1, 32'h100, 1, 32'h100, 32'h200, 1, 1, 0, 32'h200);
    vecs[8]  = mk("t2",         0, 0, 32'h0,   1, 32'h100, 32'h200, 1, 0, 0, 32'h0);
    vecs[9]  = mk("t3",         0, 0, 32'h0,   1, 32'h100, 32'h200, 1, 0, 0, 32'h0);
    vecs[10] = mk("t4",         0, 0, 32'h0,   1, 32'h100, 32'h200, 1, 0, 0, 32'h0);
    vecs[11] = mk("satHigh",    0, 1, 32'h100, 0, 0, 0, 0,             1, 1, 32'h200);
    vecs[12] = mk("ntFrom3",    0, 0, 32'h0,   1, 32'h100, 32'h200, 0, 0, 0, 32'h0);
    vecs[13] = mk("satHighA",   0, 1, 32'h100, 0, 0, 0, 0,             1, 1, 32'h200);
    vecs[14] = mk("ntFrom2",    0, 0, 32'h0,   1, 32'h100, 32'h200, 0, 0, 0, 32'h0);
    vecs[15] = mk("satHighB",   0, 1, 32'h100, 0, 0, 0, 0,             1, 0, 32'h200);
    vecs[16] = mk("sameCycTgt", 0, 1, 32'h100, 1, 32'h100, 32'h300, 1, 1, 0, 32'h200);
    vecs[17] = mk("tgtFix",     0, 1, 32'h100, 0, 0, 0, 0,             1, 1, 32'h300);
    vecs[18] = mk("noLookup",   0, 0, 32'h100, 0, 0, 0, 0,             0, 0, 32'h0);
`ifdef BTB_PRED_BYPASS_EN
    vecs[16].expTaken = 1'b1;
    vecs[16].expPc    = 32'h300;
`endif

    reset_n = 1'b0;
    flush_i = 0; lkp_v_i = 0; lkp_pc_i = 0;
    upd_v_i = 0; upd_pc_i = 0; upd_target_i = 0; upd_taken_i = 0;
    #12;
    checks++;
    if (pred_v_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_pc_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL resetOut: got v=%0b taken=%0b pc=%h, required all zero",
               pred_v_o, pred_taken_o, pred_pc_o);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) cycle(vecs[i]);

    // Asynchronous reset while a hit is on the outputs. The outputs must
    // clear without waiting for an edge, and the table must be emptied.
    cycle(mk("preRstHit", 0, 1, 32'h100, 0, 0, 0, 0, 1, 1, 32'h300));
    applyStimulus(mk("asyncRst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    #2 reset_n = 1'b0;
    #1 checkOutput();
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(mk("postRstMiss", 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h0));

    // Fill all eight entries through free slots. The pointer stays at 0, so
    // the next two allocations replace entries 0 and 1 in turn.
    for (int k = 0; k < 8; k++)
      cycle(mk("fill", 0, 0, 0, 1, 32'(k * 4), 32'h1000 + 32'(k * 4), 1, 0, 0, 32'h0));
    cycle(mk("alloc40", 0, 0, 0, 1, 32'h40, 32'h2040, 1, 0, 0, 32'h0));
    cycle(mk("alloc44", 0, 0, 0, 1, 32'h44, 32'h2044, 1, 0, 0, 32'h0));
    cycle(mk("evict0",  0, 1, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0));
    cycle(mk("hit40",   0, 1, 32'h40, 0, 0, 0, 0, 1, 1, 32'h2040));
    cycle(mk("evict4",  0, 1, 32'h4,  0, 0, 0, 0, 0, 0, 32'h0));
    cycle(mk("hit44",   0, 1, 32'h44, 0, 0, 0, 0, 1, 1, 32'h2044));
    cycle(mk("keep8",   0, 1, 32'h8,  0, 0, 0, 0, 1, 1, 32'h1008));

    // A not-taken hit only decrements the counter and leaves the target.
    // A not-taken miss allocates nothing.
    cycle(mk("nt8",     0, 0, 0, 1, 32'h8, 32'h999, 0, 0, 0, 32'h0));
    cycle(mk("nt8Tgt",  0, 1, 32'h8,  0, 0, 0, 0, 1, 0, 32'h1008));
    cycle(mk("ntMiss",  0, 0, 0, 1, 32'h80, 32'h880, 0, 0, 0, 32'h0));
    cycle(mk("noAlloc", 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 32'h0));

    // The pointer now sits at 2, so the next allocation displaces 0x8.
    cycle(mk("alloc48", 0, 0, 0, 1, 32'h48, 32'h2048, 1, 0, 0, 32'h0));
    cycle(mk("evict8",  0, 1, 32'h8,  0, 0, 0, 0, 0, 0, 32'h0));
    cycle(mk("hit48",   0, 1, 32'h48, 0, 0, 0, 0, 1, 1, 32'h2048));

    // Flush with a simultaneous taken update of a new PC and a lookup.
`ifdef BTB_PRED_BYPASS_EN
    cycle(mk("flushLkp", 1, 1, 32'h40, 1, 32'h500, 32'h5000, 1, 0, 0, 32'h0));
`else
    cycle(mk("flushLkp", 1, 1, 32'h40, 1, 32'h500, 32'h5000, 1, 1, 1, 32'h2040));
`endif
    cycle(mk("flushMiss40",  0, 1, 32'h40,  0, 0, 0, 0, 0, 0, 32'h0));
    cycle(mk("flushNoAlloc", 0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 32'h0));
    cycle(mk("flushMiss44",  0, 1, 32'h44,  0, 0, 0, 0, 0, 0, 32'h0));

    // After the flush, allocation works again from a free slot.
    cycle(mk("alloc600", 0, 0, 0, 1, 32'h600, 32'h6000, 1, 0, 0, 32'h0));
    cycle(mk("hit600",   0, 1, 32'h600, 0, 0, 0, 0, 1, 1, 32'h6000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_pred_mw.md
Name: btb_pred_mw

Overview:
- Parametrised successor to the 4-entry fully-associative branch predictor.
- Fully-associative branch target buffer with per-entry saturating counters of configurable width.
- Separate ports:
  - fetch-side lookup port, registered output, 1-cycle latency;
  - branch-unit update port.
- Adds: first-invalid-then-round-robin allocation, allocate-on-taken-only, target correction on hit, global flush, and a hit/miss-qualified update path.
- Sits between fetch (lookup) and the branch unit (update).

Parameters:
- ENTRIES, 8, number of BTB entries; power of two, 2..64.
- CNT_W, 2, saturating counter width; 1..4.
- XLEN, riscv_pkg XLEN, address/target width; the package value is always used.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush_i  in  1  invalidate all entries next edge.
- lkp_v_i  in  1  lookup request valid.
- lkp_pc_i  in  XLEN  fetch PC to look up.
- pred_v_o  out  1  registered: lookup of previous cycle hit a valid entry.
- pred_taken_o  out  1  registered: hit entry counter MSB.
- pred_pc_o  out  XLEN  registered: hit entry target; 0 on miss.
- upd_v_i  in  1  branch-unit resolution valid.
- upd_pc_i  in  XLEN  resolved branch PC.
- upd_target_i  in  XLEN  resolved branch target.
- upd_taken_i  in  1  resolved direction.

Behaviour:
- Reset:
  - all entries invalid; counters = 2^(CNT_W-1) (weakly taken); round-robin pointer = 0.
  - pred_v_o = 0, pred_taken_o = 0, pred_pc_o = 0.
- Lookup:
  - Hit = valid & tag == lkp_pc_i, full XLEN compare.
  - At most one entry may match; the allocation rules guarantee this.
  - Outputs register at the next edge after lkp_v_i.
  - If lkp_v_i = 0, pred_v_o = 0 and the other outputs are 0 next cycle.
- Update hit (upd_v_i & matching valid entry):
  - Counter +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0.
  - If taken and upd_target_i differs from the stored target, overwrite the target.
- Update miss:
  - upd_taken_i = 1: allocate. Victim is the lowest-index invalid entry, else the entry at the round-robin pointer.
    - Write tag and target, set valid, counter = 2^(CNT_W-1).
    - Pointer advances (mod ENTRIES) only when the victim was the pointer entry.
  - upd_taken_i = 0: no state change.
- Lookup and update in the same cycle:
  - Lookup reads pre-update state (read-before-write), even for the same PC.
- Flush:
  - All valid bits cleared at the next edge; counters, targets and pointer keep their values.
  - Flush has priority over a simultaneous update; the update is dropped.
  - A lookup in the flush cycle still sees pre-flush state.
- pred_v_o/pred_taken_o/pred_pc_o are unaffected by flush until the next lookup registers.
- Asynchronous reset mid-operation returns everything to the reset values immediately.
- Pointer width: clog2(ENTRIES); wraps ENTRIES-1 -> 0.

Optional Feature:
- Macro: BTB_PRED_BYPASS_EN.
- Defined:
  - A lookup matching upd_pc_i in the same cycle as a valid update sees the post-update counter and target.
  - A taken-miss allocation is visible to a same-cycle lookup of the same PC.
  - Flush still has priority: a lookup in a flush cycle returns miss.
- Undefined: read-before-write as above.

Test Plan:
- Reset, lookup 0x100 -> next cycle pred_v_o = 0, pred_taken_o = 0, pred_pc_o = 0.
- Update pc 0x100 target 0x200 taken, then lookup 0x100 -> pred_v_o = 1, pred_taken_o = 1, pred_pc_o = 0x200.
- CNT_W = 2, entry at 0x100 (init 2):
  - 2 not-taken updates -> counter 0; third not-taken stays 0; lookup taken = 0.
  - 4 taken updates -> counter saturates at 3; lookup taken = 1.
- ENTRIES = 8:
  - taken-allocate 8 distinct PCs 0x0..0x1C, then 0x40 -> replaces entry 0 (PC 0x0);
  - next new PC 0x44 replaces entry 1;
  - lookup 0x0 -> miss, lookup 0x40 -> hit.
- Same-cycle update (0x100 -> 0x300 taken) and lookup of 0x100 holding target 0x200:
  - without macro -> pred_pc_o = 0x200;
  - with BTB_PRED_BYPASS_EN -> pred_pc_o = 0x300.
- Flush with a simultaneous taken update of a new PC -> all subsequent lookups miss, and the new PC is not allocated.
